// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// opcode field position, PC width/increment and next-PC select codes.
package instr_fetch_pkg;

  localparam int          PC_W   = 16;
  localparam logic [15:0] PC_INC = 16'd2;

  // Opcode field inside the instruction word
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;

  // Fetch FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Next-PC select codes driven by the FSM into fetch_pc
  typedef logic [1:0] pc_sel_t;
  localparam pc_sel_t PC_KEEP  = 2'd0;
  localparam pc_sel_t PC_INCR  = 2'd1;
  localparam pc_sel_t PC_REDIR = 2'd2;
  localparam pc_sel_t PC_PEND  = 2'd3;

  // Instructions are halfword aligned, so bit 0 of any address is dropped
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter and pending-redirect register for the fetch unit.
// The FSM in instr_fetch chooses the next PC source; this block only
// holds the registers and performs the selected update.
module fetch_pc
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  pc_sel,
  input  logic        pend_we,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc,
  output logic [15:0] pending
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;

  // Next-PC selection; pending is overwritten by the latest redirect
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    case (pc_sel)
      PC_INCR:  pc_d = pc_q + PC_INC;
      PC_REDIR: pc_d = align_pc(redirect_pc);
      PC_PEND:  pc_d = pend_q;
      default:  pc_d = pc_q;
    endcase
    if (pend_we) begin
      pend_d = align_pc(redirect_pc);
    end
  end

  // PC and pending registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q   <= align_pc(RESET_PC);
      pend_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
    end
  end

  assign pc      = pc_q;
  assign pending = pend_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests instructions from memory, holds one in
// the instruction register until decode accepts it, and handles branch
// redirects, including ones that arrive while a memory read is in flight.
//
// Handshakes: imem_req/imem_ack - imem_req and imem_addr stay constant
// until imem_ack is seen; a read completes only in a cycle with both high.
// instr_valid/instr_ready - an instruction is handed off only in a cycle
// with both high; instr, op and pc_out stay constant while instr_valid is
// high and not yet accepted.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          IW       = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [15:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr,
  output logic [3:0]    op,
  output logic [15:0]   pc_out,
  input  logic          redirect_valid,
  input  logic [15:0]   redirect_pc,
  output logic [15:0]   fetch_count,
  output logic [1:0]    dbg_state
);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ir_q;
  logic [15:0]   pc_out_q;
  logic [15:0]   count_q;

  logic [1:0]    pc_sel;
  logic          pend_we;
  logic          capture;
  logic          handoff;
  logic [15:0]   pc;
  logic [15:0]   pending;

  fetch_pc #(
    .RESET_PC(RESET_PC)
  ) u_fetch_pc (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc_sel     (pc_sel),
    .pend_we    (pend_we),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .pending    (pending)
  );

  // FSM next state and PC control; redirect wins over every other event
  always_comb begin
    state_d = state_q;
    pc_sel  = PC_KEEP;
    pend_we = 1'b0;
    capture = 1'b0;
    handoff = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect_valid) pc_sel = PC_REDIR;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_sel  = PC_REDIR;
            state_d = ST_FETCH;
          end else begin
            // Read still in flight: remember the target, wait for the ack
            pend_we = 1'b1;
            state_d = ST_DRAIN;
          end
        end else if (imem_ack) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_sel  = PC_REDIR;
            state_d = ST_FETCH;
          end else begin
            pend_we = 1'b1;
          end
        end else if (imem_ack) begin
          pc_sel  = PC_PEND;
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          // Held instruction is on the wrong path: squash without counting
          pc_sel  = PC_REDIR;
          state_d = ST_FETCH;
        end else if (instr_ready) begin
          pc_sel  = PC_INCR;
          handoff = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, instruction register, instruction PC and handoff counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      pc_out_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        ir_q     <= imem_rdata;
        pc_out_q <= pc;
      end
      if (handoff) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // Reset gates the handshake outputs so nothing escapes while reset is held
  assign imem_req    = reset_n && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
  assign instr_valid = reset_n && (state_q == ST_HOLD);
  assign imem_addr   = pc;
  assign instr       = ir_q;
  assign op          = ir_q[OP_MSB:OP_LSB];
  assign pc_out      = pc_out_q;
  assign fetch_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of the fetch unit.
module tb_instr_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          IW       = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n        = 1'b0;
  logic          imem_ack       = 1'b0;
  logic [IW-1:0] imem_rdata     = '0;
  logic          instr_ready    = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [15:0]   redirect_pc    = '0;

  logic          imem_req;
  logic [15:0]   imem_addr;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [3:0]    op;
  logic [15:0]   pc_out;
  logic [15:0]   fetch_count;
  logic [1:0]    dbg_state;

  instr_fetch #(.RESET_PC(RESET_PC), .IW(IW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .op            (op),
    .pc_out        (pc_out),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_count   (fetch_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks what the unit is doing in transaction terms: whether a read is
  // outstanding, whether its data will be thrown away, where fetching goes
  // next, and which instruction (if any) is waiting for decode.
  bit          m_live    = 0;  // model has seen a reset
  bit          m_waking  = 0;  // first cycle out of reset, no request yet
  bit          m_busy    = 0;  // a memory read is outstanding
  bit          m_discard = 0;  // outstanding read belongs to a squashed path
  bit          m_held    = 0;  // an instruction waits for decode
  int unsigned m_pc      = 0;  // address of the next read
  int unsigned m_target  = 0;  // where to go after a discarded read
  int unsigned m_ir      = 0;
  int unsigned m_pcout   = 0;
  int unsigned m_count   = 0;
  logic [IW-1:0] exp_q[$];     // instructions expected at decode, in order

  function automatic int unsigned even(input logic [15:0] a);
    return int'(a) & 32'hFFFE;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      m_live = 1; m_waking = 1; m_busy = 0; m_discard = 0; m_held = 0;
      m_pc = even(RESET_PC); m_target = 0; m_ir = 0; m_pcout = 0; m_count = 0;
      exp_q.delete();
    end else if (m_live) begin
      if (m_waking) begin
        m_waking = 0;
        m_busy   = 1;
        if (redirect_valid) m_pc = even(redirect_pc);
      end else if (m_busy) begin
        if (redirect_valid) begin
          if (imem_ack) begin
            m_pc = even(redirect_pc); m_discard = 0;
          end else begin
            m_target = even(redirect_pc); m_discard = 1;
          end
        end else if (imem_ack) begin
          if (m_discard) begin
            m_pc = m_target; m_discard = 0;
          end else begin
            m_busy = 0; m_held = 1; m_ir = int'(imem_rdata); m_pcout = m_pc;
            exp_q.push_back(imem_rdata);
          end
        end
      end else if (m_held) begin
        if (redirect_valid) begin
          m_held = 0; m_busy = 1; m_pc = even(redirect_pc);
          void'(exp_q.pop_back());
        end else if (instr_ready) begin
          m_held = 0; m_busy = 1; m_pc = (m_pc + 2) % 65536;
          m_count = (m_count + 1) % 65536;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Single compare process: every falling edge once the model is live
  always @(negedge clock) begin
    if (m_live) begin
      chk("imem_req", 32'(imem_req), 32'(m_busy));
      if (m_busy) chk("imem_addr", 32'(imem_addr), m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_held));
      chk("instr", 32'(instr), m_ir);
      chk("op", 32'(op), (m_ir >> 12) & 32'hF);
      chk("pc_out", 32'(pc_out), m_pcout);
      chk("fetch_count", 32'(fetch_count), m_count);
      if (m_held && exp_q.size() > 0) chk("held_order", 32'(instr), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: the rising edge consumes the current inputs; return just
  // after the falling edge so outputs are settled and inputs can change.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic set_in(input bit rst_n, input bit ack, input logic [15:0] rdata,
                        input bit rdy, input bit redir, input logic [15:0] rpc);
    reset_n = rst_n; imem_ack = ack; imem_rdata = rdata;
    instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    set_in(0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_count", 32'(fetch_count), 0);
    chk("rst_instr", 32'(instr), 0);

    // First fetch, 1-cycle ack, immediate accept
    set_in(1, 0, 0, 1, 0, 0); step();
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", 32'(imem_addr), 32'h0000);
    set_in(1, 1, 16'h0123, 1, 0, 0); step();
    chk("first_valid", 32'(instr_valid), 1);
    chk("first_op", 32'(op), 0);
    chk("first_pcout", 32'(pc_out), 32'h0000);
    chk("first_instr", 32'(instr), 32'h0123);
    set_in(1, 0, 0, 1, 0, 0); step();
    chk("next_addr", 32'(imem_addr), 32'h0002);
    chk("count_1", 32'(fetch_count), 1);

    // Decode stalls for 5 cycles in HOLD
    set_in(1, 1, 16'hA5A5, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_instr", 32'(instr), 32'hA5A5);
      chk("stall_pcout", 32'(pc_out), 32'h0002);
      chk("stall_req", 32'(imem_req), 0);
      chk("stall_count", 32'(fetch_count), 1);
    end
    set_in(1, 0, 0, 1, 0, 0); step();
    chk("stall_accept_count", 32'(fetch_count), 2);
    chk("stall_next_addr", 32'(imem_addr), 32'h0004);

    // Redirect while a read is outstanding, ack 3 cycles later
    set_in(1, 0, 0, 0, 1, 16'h0040); step();
    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("drain_addr", 32'(imem_addr), 32'h0004);
      chk("drain_req", 32'(imem_req), 1);
      step();
    end
    set_in(1, 1, 16'hFFFF, 0, 0, 0); step();
    chk("drain_dropped", 32'(instr_valid), 0);
    chk("drain_target", 32'(imem_addr), 32'h0040);

    // Redirect in HOLD together with instr_ready squashes the instruction
    set_in(1, 1, 16'h1234, 0, 0, 0); step();
    chk("hold_pcout", 32'(pc_out), 32'h0040);
    set_in(1, 0, 0, 1, 1, 16'h0081); step();
    chk("squash_addr", 32'(imem_addr), 32'h0080);
    chk("squash_count", 32'(fetch_count), 2);

    // PC wrap at 16'hFFFE
    set_in(1, 1, 16'h7777, 0, 1, 16'hFFFE); step();
    chk("wrap_start", 32'(imem_addr), 32'hFFFE);
    set_in(1, 1, 16'h2222, 0, 0, 0); step();
    chk("wrap_pcout", 32'(pc_out), 32'hFFFE);
    chk("wrap_op", 32'(op), 2);
    set_in(1, 0, 0, 1, 0, 0); step();
    chk("wrap_addr", 32'(imem_addr), 32'h0000);
    chk("wrap_count", 32'(fetch_count), 3);

    // Reset during DRAIN, then a late ack
    set_in(1, 0, 0, 0, 1, 16'h0100); step();
    chk("drain2_req", 32'(imem_req), 1);
    set_in(0, 0, 0, 0, 0, 0); step();
    chk("drain_rst_req", 32'(imem_req), 0);
    chk("drain_rst_count", 32'(fetch_count), 0);
    set_in(1, 1, 16'hDEAD, 0, 0, 0); step();
    chk("late_ack_req", 32'(imem_req), 1);
    chk("late_ack_addr", 32'(imem_addr), 32'(RESET_PC));
    set_in(1, 0, 0, 0, 0, 0); step();
    chk("late_ack_valid", 32'(instr_valid), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] rpc;
      bit          ack;
      rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      if (m_busy)        ack = ($urandom_range(0, 2) == 0);
      else if (m_waking) ack = ($urandom_range(0, 3) == 0);
      else               ack = 0;
      set_in(($urandom_range(0, 149) != 0), ack, 16'($urandom),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), rpc);
      step();
    end

    set_in(1, 0, 0, 0, 0, 0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
